// File: rtl/register_file.sv
// Architectural register file with per-register rename tags for the RV32I out-of-order core.
// Each operand read returns either a ready value or the ROB id it still waits on. Pending
// operands can be satisfied by a same-cycle commit (bypass) or by the ROB's ready ports.
module register_file #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1Dirty,
  output logic [31:0]          rs1Value,
  output logic [ROB_WIDTH-1:0] rs1DepId,
  output logic                 rs2Dirty,
  output logic [31:0]          rs2Value,
  output logic [ROB_WIDTH-1:0] rs2DepId,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  input  logic                 rs1Ready,
  input  logic [31:0]          rs1RobValue,
  output logic [ROB_WIDTH-1:0] rs2Dep,
  input  logic                 rs2Ready,
  input  logic [31:0]          rs2RobValue
);

  logic [31:0]          r_value [32];
  logic [31:0]          r_busy;
  logic [ROB_WIDTH-1:0] r_tag   [32];

  logic [32:0] w_rs1_res;
  logic [32:0] w_rs2_res;

  // Resolve one operand; result is {dirty, value}. Priority: x0, idle register, commit
  // bypass, ROB forward, otherwise still pending (value is a don't-care stale copy).
  function automatic logic [32:0] read_operand(input logic [4:0]  r,
                                               input logic        rob_ready,
                                               input logic [31:0] rob_value);
    logic [32:0] res;
    if (r == 5'd0) begin
      res = {1'b0, 32'd0};
    end else if (!r_busy[r]) begin
      res = {1'b0, r_value[r]};
    end else if (regUpdateValid && (regUpdateDest == r) && (regUpdateRobId == r_tag[r])) begin
      res = {1'b0, regValue};
    end else if (rob_ready) begin
      res = {1'b0, rob_value};
    end else begin
      res = {1'b1, r_value[r]};
    end
    return res;
  endfunction

  // Operand 1 lookup
  always_comb begin
    w_rs1_res = read_operand(rs1, rs1Ready, rs1RobValue);
  end

  // Operand 2 lookup
  always_comb begin
    w_rs2_res = read_operand(rs2, rs2Ready, rs2RobValue);
  end

  assign rs1Dirty = w_rs1_res[32];
  assign rs1Value = w_rs1_res[31:0];
  assign rs1DepId = r_tag[rs1];
  assign rs1Dep   = r_tag[rs1];
  assign rs2Dirty = w_rs2_res[32];
  assign rs2Value = w_rs2_res[31:0];
  assign rs2DepId = r_tag[rs2];
  assign rs2Dep   = r_tag[rs2];

  // Commit, rename and clear; later assignments override earlier ones so a same-cycle
  // rename beats the commit's busy release, and clear beats both.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_busy <= '0;
      for (int i = 0; i < 32; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      if (regUpdateValid && (regUpdateDest != 5'd0)) begin
        r_value[regUpdateDest] <= regValue;
        // Only release when no younger writer has renamed the register since.
        if (r_tag[regUpdateDest] == regUpdateRobId) begin
          r_busy[regUpdateDest] <= 1'b0;
        end
      end
      if (clear) begin
        r_busy <= '0;
      end else if (renameValid && (renameDest != 5'd0)) begin
        r_busy[renameDest] <= 1'b1;
        r_tag[renameDest]  <= renameRobId;
      end
    end
  end

endmodule
